// File: rtl/vga_mem_arbiter_if.sv
// CPU/RAM bus of the VGA memory arbiter.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU request (master -> arbiter)
//   cpu_ready/cpu_rdata/cpu_rvalid    : CPU response (arbiter -> master)
//   mem_en/mem_we/mem_addr/mem_wdata  : single-port video RAM command
//   mem_rdata                         : RAM read data, one cycle after a read
// The arbiter connects through the slave modport; the CPU/RAM side uses master.
interface vga_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [23:0] cpu_wdata;
  logic        cpu_ready;
  logic [23:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ready, cpu_rdata, cpu_rvalid, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ready, cpu_rdata, cpu_rvalid, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Arbitrates one single-port video RAM between VGA scanout and a CPU.
// Scanout always wins; CPU reads and buffered CPU writes only use blanking.
// Ports:
//   pclk, resetn     : pixel clock, async active-low reset
//   valid            : display-active flag from the timing controller
//   h_addr, v_addr   : current pixel column / row
//   vga_data         : pixel RGB888, two cycles after the scanout issue
//   bus (slave)      : CPU request/response and RAM command signals
module vga_mem_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  output logic [23:0] vga_data,
  vga_mem_arbiter_if.slave bus
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [19:0]   PIX_MAX  = 20'(H_RES * V_RES);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD_PEND, RD_WAIT} state_t;

  state_t        state, state_nxt;
  logic [18:0]   fifo_addr [FIFO_DEPTH];
  logic [23:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [18:0]   rd_addr;
  logic [18:0]   scan_addr;
  logic [18:0]   head_addr;
  logic [23:0]   head_data;
  logic          vld_d;
  logic          fifo_empty, fifo_full;
  logic          accept, push, rd_accept, rd_issue, pop;
  logic          rd_in_range, head_in_range;

  // Row stride 640 = 512 + 128.
  assign scan_addr = ({9'd0, v_addr} << 9) + ({9'd0, v_addr} << 7) + {9'd0, h_addr};

  assign head_addr     = fifo_addr[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];
  assign head_in_range = {1'b0, head_addr} < PIX_MAX;
  assign rd_in_range   = {1'b0, rd_addr} < PIX_MAX;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // Fullness is judged on the current count so a same-cycle pop never
  // makes room for a push.
  assign accept    = resetn && bus.cpu_req && (state == IDLE) && (!bus.cpu_we || !fifo_full);
  assign push      = accept && bus.cpu_we;
  assign rd_accept = accept && !bus.cpu_we;
  // A pending read waits for the FIFO to drain so it sees earlier writes.
  assign rd_issue  = resetn && (state == RD_PEND) && !valid && fifo_empty;
  assign pop       = resetn && !valid && !rd_issue && !fifo_empty;

  assign bus.cpu_ready = accept;

  // RAM command mux; out-of-range CPU traffic keeps its slot but no strobe.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (valid) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = scan_addr;
    end else if (rd_issue) begin
      bus.mem_en   = rd_in_range;
      bus.mem_addr = rd_addr;
    end else if (pop) begin
      bus.mem_en    = head_in_range;
      bus.mem_we    = head_in_range;
      bus.mem_addr  = head_addr;
      bus.mem_wdata = head_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_accept) state_nxt = RD_PEND;
      RD_PEND: if (rd_issue)  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      rd_addr        <= '0;
      bus.cpu_rdata  <= '0;
      bus.cpu_rvalid <= 1'b0;
    end else begin
      bus.cpu_rvalid <= (state == RD_WAIT);
      if (rd_accept) rd_addr <= bus.cpu_addr;
      if (state == RD_WAIT) bus.cpu_rdata <= rd_in_range ? bus.mem_rdata : 24'd0;
    end
  end

  // Write buffer storage; contents need no reset, pointers/count do.
  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cpu_addr;
      fifo_data[wr_ptr] <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scanout return path: mem_rdata is valid the cycle after issue, and is
  // registered into vga_data at the end of that cycle.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      vld_d    <= 1'b0;
      vga_data <= '0;
    end else begin
      vld_d    <= valid;
      vga_data <= vld_d ? bus.mem_rdata : 24'd0;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a one-cycle-latency RAM model.
module tb_vga_mem_arbiter;
  logic        pclk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [9:0]  h_addr, v_addr;
  logic [23:0] vga_data;
  int          tests = 0;
  int          fails = 0;
  logic [23:0] ram [0:4095] = '{default: 24'h0};

  vga_mem_arbiter_if bus ();

  vga_mem_arbiter dut (
    .pclk(pclk), .resetn(resetn), .valid(valid),
    .h_addr(h_addr), .v_addr(v_addr), .vga_data(vga_data), .bus(bus.slave)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[11:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr[11:0]];
    end
  end

  task automatic cpu(input logic req, input logic we, input logic [18:0] a, input logic [23:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic test_reset;
    resetn = 1'b0; valid = 1'b0; h_addr = '0; v_addr = '0;
    cpu(1'b1, 1'b1, 19'd9, 24'h111111);
    @(negedge pclk); #1;
    tests++; if (bus.cpu_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", bus.cpu_ready); end
    tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL rst_strobe got en=%b we=%b exp 0/0", bus.mem_en, bus.mem_we); end
    tests++; if (vga_data !== 24'h0) begin fails++; $display("FAIL rst_vga got %h exp 0", vga_data); end
    tests++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 24'h0) begin fails++; $display("FAIL rst_rd got rv=%b rd=%h exp 0/0", bus.cpu_rvalid, bus.cpu_rdata); end
    @(negedge pclk); valid = 1'b1; h_addr = 10'd1; #1;
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 19'd1) begin fails++; $display("FAIL rst_scan got en=%b we=%b a=%0d exp 1/0/1", bus.mem_en, bus.mem_we, bus.mem_addr); end
    tests++; if (bus.cpu_ready !== 1'b0) begin fails++; $display("FAIL rst_ready2 got %b exp 0", bus.cpu_ready); end
    @(negedge pclk); resetn = 1'b1; valid = 1'b0; cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.mem_en !== 1'b0) begin fails++; $display("FAIL rst_fifo_empty got en=%b exp 0", bus.mem_en); end
  endtask

  task automatic test_scanout;
    @(negedge pclk); cpu(1'b1, 1'b1, 19'd1285, 24'hABCDEF); #1;
    tests++; if (bus.cpu_ready !== 1'b1) begin fails++; $display("FAIL scan_preload_ready got %b exp 1", bus.cpu_ready); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'd1285) begin fails++; $display("FAIL scan_preload_drain got we=%b a=%0d exp 1/1285", bus.mem_we, bus.mem_addr); end
    @(negedge pclk); valid = 1'b1; h_addr = 10'd5; v_addr = 10'd2; #1;
    tests++; if (bus.mem_addr !== 19'd1285 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL scan_addr got a=%0d en=%b we=%b exp 1285/1/0", bus.mem_addr, bus.mem_en, bus.mem_we); end
    @(negedge pclk); valid = 1'b0; #1;
    tests++; if (vga_data !== 24'h0) begin fails++; $display("FAIL scan_early got %h exp 0", vga_data); end
    @(negedge pclk); #1;
    tests++; if (vga_data !== 24'hABCDEF) begin fails++; $display("FAIL scan_data got %h exp abcdef", vga_data); end
    @(negedge pclk); #1;
    tests++; if (vga_data !== 24'h0) begin fails++; $display("FAIL scan_blank got %h exp 0", vga_data); end
    @(negedge pclk); valid = 1'b1; h_addr = 10'd639; v_addr = 10'd479; #1;
    tests++; if (bus.mem_addr !== 19'd307199) begin fails++; $display("FAIL scan_last got %0d exp 307199", bus.mem_addr); end
    @(negedge pclk); h_addr = 10'd0; v_addr = 10'd1; #1;
    tests++; if (bus.mem_addr !== 19'd640) begin fails++; $display("FAIL scan_row1 got %0d exp 640", bus.mem_addr); end
    @(negedge pclk); valid = 1'b0;
  endtask

  task automatic test_write_active;
    @(negedge pclk); valid = 1'b1; cpu(1'b1, 1'b1, 19'd100, 24'h123456); #1;
    tests++; if (bus.cpu_ready !== 1'b1 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL wact_accept got rdy=%b we=%b exp 1/0", bus.cpu_ready, bus.mem_we); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL wact_hold got we=%b exp 0", bus.mem_we); end
    @(negedge pclk); valid = 1'b0; #1;
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 19'd100 || bus.mem_wdata !== 24'h123456) begin
      fails++; $display("FAIL wact_drain got en=%b we=%b a=%0d d=%h exp 1/1/100/123456", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    @(negedge pclk); #1;
    tests++; if (bus.mem_en !== 1'b0) begin fails++; $display("FAIL wact_empty got en=%b exp 0", bus.mem_en); end
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk); valid = 1'b1; cpu(1'b1, 1'b1, 19'(200 + i), 24'(24'h100 + i)); #1;
      tests++; if (bus.cpu_ready !== (i < 4)) begin fails++; $display("FAIL full_ready%0d got %b exp %b", i, bus.cpu_ready, (i < 4)); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      if (i == 0) begin valid = 1'b0; cpu(1'b0, 1'b0, 19'd0, 24'h0); end
      #1;
      tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'(200 + i) || bus.mem_wdata !== 24'(24'h100 + i)) begin
        fails++; $display("FAIL full_drain%0d got we=%b a=%0d d=%h exp 1/%0d/%h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, 200 + i, 24'h100 + i); end
    end
    @(negedge pclk); cpu(1'b1, 1'b1, 19'd204, 24'h000104); #1;
    tests++; if (bus.cpu_ready !== 1'b1 || bus.mem_en !== 1'b0) begin fails++; $display("FAIL full_fifth got rdy=%b en=%b exp 1/0", bus.cpu_ready, bus.mem_en); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'd204) begin fails++; $display("FAIL full_fifth_drain got we=%b a=%0d exp 1/204", bus.mem_we, bus.mem_addr); end
  endtask

  task automatic test_raw;
    @(negedge pclk); cpu(1'b1, 1'b1, 19'd7, 24'h00FF00); #1;
    tests++; if (bus.cpu_ready !== 1'b1) begin fails++; $display("FAIL raw_wr_ready got %b exp 1", bus.cpu_ready); end
    @(negedge pclk); cpu(1'b1, 1'b0, 19'd7, 24'h0); #1;
    tests++; if (bus.cpu_ready !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 19'd7) begin
      fails++; $display("FAIL raw_wr_first got rdy=%b we=%b a=%0d exp 1/1/7", bus.cpu_ready, bus.mem_we, bus.mem_addr); end
    @(negedge pclk); cpu(1'b1, 1'b1, 19'd8, 24'h0); #1;
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 19'd7) begin
      fails++; $display("FAIL raw_rd_issue got en=%b we=%b a=%0d exp 1/0/7", bus.mem_en, bus.mem_we, bus.mem_addr); end
    tests++; if (bus.cpu_ready !== 1'b0) begin fails++; $display("FAIL raw_busy1 got %b exp 0", bus.cpu_ready); end
    @(negedge pclk); #1;
    tests++; if (bus.cpu_ready !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin fails++; $display("FAIL raw_busy2 got rdy=%b rv=%b exp 0/0", bus.cpu_ready, bus.cpu_rvalid); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 24'h00FF00) begin fails++; $display("FAIL raw_rdata got rv=%b rd=%h exp 1/00ff00", bus.cpu_rvalid, bus.cpu_rdata); end
    @(negedge pclk); #1;
    tests++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 24'h00FF00) begin fails++; $display("FAIL raw_hold got rv=%b rd=%h exp 0/00ff00", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_read_priority;
    @(negedge pclk); cpu(1'b1, 1'b0, 19'd1285, 24'h0); #1;
    tests++; if (bus.cpu_ready !== 1'b1 || bus.mem_en !== 1'b0) begin fails++; $display("FAIL prio_accept got rdy=%b en=%b exp 1/0", bus.cpu_ready, bus.mem_en); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); valid = 1'b1; h_addr = 10'd3; v_addr = 10'd0; #1;
    tests++; if (bus.mem_addr !== 19'd3 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL prio_scan got a=%0d we=%b exp 3/0", bus.mem_addr, bus.mem_we); end
    @(negedge pclk); valid = 1'b0; #1;
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 19'd1285) begin
      fails++; $display("FAIL prio_issue got en=%b we=%b a=%0d exp 1/0/1285", bus.mem_en, bus.mem_we, bus.mem_addr); end
    @(negedge pclk); #1;
    @(negedge pclk); #1;
    tests++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 24'hABCDEF) begin fails++; $display("FAIL prio_rdata got rv=%b rd=%h exp 1/abcdef", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_out_of_range;
    @(negedge pclk); cpu(1'b1, 1'b1, 19'd307200, 24'h777777); #1;
    tests++; if (bus.cpu_ready !== 1'b1) begin fails++; $display("FAIL oor_wr_ready got %b exp 1", bus.cpu_ready); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL oor_wr_drop got en=%b we=%b exp 0/0", bus.mem_en, bus.mem_we); end
    @(negedge pclk); cpu(1'b1, 1'b0, 19'd400000, 24'h0); #1;
    tests++; if (bus.cpu_ready !== 1'b1) begin fails++; $display("FAIL oor_rd_ready got %b exp 1", bus.cpu_ready); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.mem_en !== 1'b0) begin fails++; $display("FAIL oor_rd_nostrobe got en=%b exp 0", bus.mem_en); end
    @(negedge pclk); #1;
    tests++; if (bus.cpu_rvalid !== 1'b0) begin fails++; $display("FAIL oor_rd_early got %b exp 0", bus.cpu_rvalid); end
    @(negedge pclk); #1;
    tests++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 24'h0) begin fails++; $display("FAIL oor_rd_data got rv=%b rd=%h exp 1/0", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_reset_mid_read;
    @(negedge pclk); cpu(1'b1, 1'b0, 19'd7, 24'h0); #1;
    tests++; if (bus.cpu_ready !== 1'b1) begin fails++; $display("FAIL rmid_accept got %b exp 1", bus.cpu_ready); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 19'd7) begin fails++; $display("FAIL rmid_issue got en=%b a=%0d exp 1/7", bus.mem_en, bus.mem_addr); end
    @(negedge pclk); resetn = 1'b0; #1;
    tests++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 24'h0) begin fails++; $display("FAIL rmid_clear got rv=%b rd=%h exp 0/0", bus.cpu_rvalid, bus.cpu_rdata); end
    @(negedge pclk); resetn = 1'b1; #1;
    tests++; if (bus.cpu_rvalid !== 1'b0) begin fails++; $display("FAIL rmid_nopulse1 got %b exp 0", bus.cpu_rvalid); end
    @(negedge pclk); cpu(1'b1, 1'b0, 19'd7, 24'h0); #1;
    tests++; if (bus.cpu_rvalid !== 1'b0) begin fails++; $display("FAIL rmid_nopulse2 got %b exp 0", bus.cpu_rvalid); end
    tests++; if (bus.cpu_ready !== 1'b1) begin fails++; $display("FAIL rmid_reaccept got %b exp 1", bus.cpu_ready); end
    @(negedge pclk); cpu(1'b0, 1'b0, 19'd0, 24'h0); #1;
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 19'd7) begin
      fails++; $display("FAIL rmid_reissue got en=%b we=%b a=%0d exp 1/0/7", bus.mem_en, bus.mem_we, bus.mem_addr); end
    @(negedge pclk); #1;
    @(negedge pclk); #1;
    tests++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 24'h00FF00) begin fails++; $display("FAIL rmid_rdata got rv=%b rd=%h exp 1/00ff00", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  initial begin
    test_reset;
    test_scanout;
    test_write_active;
    test_fifo_full;
    test_raw;
    test_read_priority;
    test_out_of_range;
    test_reset_mid_read;
    @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
